// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hack_pkg
//  Description : Shared definitions for the Hack control sequencer: the
//                sequencer state encoding, instruction field bit positions
//                and the default reset program counter.
//  Revision    : 1.0  initial release
// ============================================================================
package hack_pkg;

  // Sequencer states; 3 bits covers the five states.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEMRD  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEMWR  = 3'd4
  } state_e;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  // Instruction field positions
  localparam int c_inst_type_bit = 15;  // 0 = A-instruction, 1 = C-instruction
  localparam int c_inst_a_bit    = 12;  // ALU y operand: 0 = A, 1 = M
  localparam int c_comp_hi       = 11;  // zx nx zy ny f no
  localparam int c_comp_lo       = 6;
  localparam int c_dest_a_bit    = 5;   // d1
  localparam int c_dest_d_bit    = 4;   // d2
  localparam int c_dest_m_bit    = 3;   // d3
  localparam int c_jump_hi       = 2;   // j1 j2 j3
  localparam int c_jump_lo       = 0;

endpackage
`default_nettype wire

// File: rtl/hack_jump_eval.sv
`default_nettype none
// ============================================================================
//  Module      : hack_jump_eval
//  Description : Combinational Hack jump condition. jump[2] tests out<0,
//                jump[1] tests out==0, jump[0] tests out>0.
//  Ports       : jump[2:0] in  - j1 j2 j3 instruction field
//                zr        in  - ALU zero flag
//                ng        in  - ALU negative flag
//                take      out - jump is taken
//  Revision    : 1.0  initial release
// ============================================================================
module hack_jump_eval (
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  always_comb begin
    take = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);
  end

endmodule
`default_nettype wire

// File: rtl/hack_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hack_cpu_sequencer
//  Description : Multi-cycle Hack control sequencer. Owns A, D and PC,
//                fetches instructions and performs M reads/writes over
//                req/ack handshakes, and drives an external combinational
//                Hack ALU.
//  Ports       : clock, reset            - clock, synchronous active-high reset
//                imem_req/addr/ack/rdata - instruction fetch handshake
//                dmem_req/we/addr/wdata/ack/rdata - data memory handshake
//                alu_x, alu_y, alu_zx..alu_no     - ALU operands and controls
//                alu_out, alu_zr, alu_ng          - ALU result and flags
//                pc, a_reg, d_reg        - architectural registers
//                halted                  - end-loop detected (optional)
//  Options     : HACK_HALT_DETECT_EN - adds the halted output; the sequencer
//                parks in FETCH with no request once a jump targets itself.
//  Revision    : 1.0  initial release
// ============================================================================
module hack_cpu_sequencer
  import hack_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [15:0] pc,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg
`ifdef HACK_HALT_DETECT_EN
  ,
  output logic        halted
`endif
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] m_q, m_d;        // latched M operand
  logic [15:0] wbuf_q, wbuf_d;  // ALU result awaiting an M write
  logic [15:0] addr_q, addr_d;  // A as it was when the instruction started
  logic        imem_req_q, imem_req_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
`ifdef HACK_HALT_DETECT_EN
  logic        halted_q, halted_d;
`endif

  logic w_take;
  logic w_imem_fire;
  logic w_dmem_fire;

  hack_jump_eval u_jump_eval (
    .jump (ir_q[c_jump_hi:c_jump_lo]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (w_take)
  );

  // Acks only count while our own request is up.
  always_comb begin
    w_imem_fire = imem_req_q & imem_ack;
    w_dmem_fire = dmem_req_q & dmem_ack;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    ir_d    = ir_q;
    m_d     = m_q;
    wbuf_d  = wbuf_q;
    addr_d  = addr_q;
`ifdef HACK_HALT_DETECT_EN
    halted_d = halted_q;
`endif

    case (state_q)
      ST_FETCH: begin
        if (w_imem_fire) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // Snapshot A so the M address survives a d1 update in EXEC.
        addr_d = a_q;
        if (!ir_q[c_inst_type_bit]) begin
          a_d     = ir_q;
          pc_d    = pc_q + 16'd1;
          state_d = ST_FETCH;
        end else if (ir_q[c_inst_a_bit]) begin
          state_d = ST_MEMRD;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_MEMRD: begin
        if (w_dmem_fire) begin
          m_d     = dmem_rdata;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (ir_q[c_dest_a_bit]) a_d = alu_out;
        if (ir_q[c_dest_d_bit]) d_d = alu_out;
        wbuf_d = alu_out;
        // a_q is still the pre-instruction A here, so it is the jump target.
        if (w_take) begin
          pc_d = a_q;
`ifdef HACK_HALT_DETECT_EN
          if (a_q == pc_q) halted_d = 1'b1;
`endif
        end else begin
          pc_d = pc_q + 16'd1;
        end
        state_d = ir_q[c_dest_m_bit] ? ST_MEMWR : ST_FETCH;
      end

      ST_MEMWR: begin
        if (w_dmem_fire) state_d = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase

    // Requests are registered from the next state so they are glitch-free
    // and drop in the cycle after the accepting ack.
`ifdef HACK_HALT_DETECT_EN
    imem_req_d = (state_d == ST_FETCH) & ~halted_d;
`else
    imem_req_d = (state_d == ST_FETCH);
`endif
    dmem_req_d = (state_d == ST_MEMRD) | (state_d == ST_MEMWR);
    dmem_we_d  = (state_d == ST_MEMWR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      a_q        <= 16'h0000;
      d_q        <= 16'h0000;
      ir_q       <= 16'h0000;
      m_q        <= 16'h0000;
      wbuf_q     <= 16'h0000;
      addr_q     <= 16'h0000;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
`ifdef HACK_HALT_DETECT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      a_q        <= a_d;
      d_q        <= d_d;
      ir_q       <= ir_d;
      m_q        <= m_d;
      wbuf_q     <= wbuf_d;
      addr_q     <= addr_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
`ifdef HACK_HALT_DETECT_EN
      halted_q   <= halted_d;
`endif
    end
  end

  always_comb begin
    imem_req   = imem_req_q;
    imem_addr  = pc_q;
    dmem_req   = dmem_req_q;
    dmem_we    = dmem_we_q;
    dmem_addr  = addr_q;
    dmem_wdata = wbuf_q;
    alu_x      = d_q;
    alu_y      = ir_q[c_inst_a_bit] ? m_q : a_q;
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_q[c_comp_hi:c_comp_lo];
    pc         = pc_q;
    a_reg      = a_q;
    d_reg      = d_q;
`ifdef HACK_HALT_DETECT_EN
    halted     = halted_q;
`endif
  end

endmodule
`default_nettype wire
